// File: rtl/burst_trap_decoder.sv
// Sequential burst-trapping decoder for a systematic cyclic (N,K) code.
// Serial syndrome division, then N-cycle error trapping with cyclic rotation.
module burst_trap_decoder #(
    parameter int N = 15,
    parameter int K = 9,
    parameter int B = 3,
    parameter logic [N-K:0] G = 7'b1111001
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_data,
    input  logic           correct_en,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [K-1:0]   out_data,
    output logic [N-K-1:0] out_syndrome,
    output logic           out_corrected,
    output logic           out_uncorrectable
);
    localparam int R  = N - K;
    localparam int CW = $clog2(N);

    if (B > R / 2) begin : g_chk_b
        $error("burst_trap_decoder: B must not exceed R/2");
    end
    if (G[R] == 1'b0) begin : g_chk_g
        $error("burst_trap_decoder: G[R] must be 1");
    end
    if (K < 1) begin : g_chk_k
        $error("burst_trap_decoder: K must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, SYND, TRAP, OUT} state_t;

    state_t          state;
    logic [N-1:0]    cw_q;
    logic [R-1:0]    s_q;
    logic [R-1:0]    syn_q;
    logic [CW-1:0]   cnt;
    logic            ce_q;
    logic            trapped_q;

    logic [N-1:0]    cw_sh;
    logic            fb;
    logic [R-1:0]    s_div;
    logic [R-1:0]    s_shift;
    logic            hit;
    logic            trap_any;
    logic            last;
    logic [N-1:0]    burst;
    logic [N-1:0]    cw_rot;
    logic [N-1:0]    cw_next;

    always_comb begin
        cw_sh    = cw_q << cnt;
        fb       = s_q[R-1] ^ cw_sh[N-1];
        s_div    = {s_q[R-2:0], 1'b0} ^ (fb ? G[R-1:0] : '0);
        s_shift  = {s_q[R-2:0], 1'b0} ^ (s_q[R-1] ? G[R-1:0] : '0);
        hit      = ce_q & (s_q != '0) & (s_q[R-1:B] == '0);
        trap_any = trapped_q | hit;
        last     = (cnt == CW'(N - 1));
        // The syndrome is premultiplied by x^R, so a trapped burst
        // sits at bit K of the rotated word rather than at bit 0.
        burst    = {{(N-B){1'b0}}, s_q[B-1:0]} << K;
        cw_rot   = hit ? (cw_q ^ burst) : cw_q;
        cw_next  = {cw_rot[N-2:0], cw_rot[N-1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            in_ready          <= 1'b1;
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_syndrome      <= '0;
            out_corrected     <= 1'b0;
            out_uncorrectable <= 1'b0;
            cw_q              <= '0;
            s_q               <= '0;
            syn_q             <= '0;
            cnt               <= '0;
            ce_q              <= 1'b0;
            trapped_q         <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        cw_q      <= in_data;
                        ce_q      <= correct_en;
                        s_q       <= '0;
                        cnt       <= '0;
                        trapped_q <= 1'b0;
                        in_ready  <= 1'b0;
                        state     <= SYND;
                    end
                end
                SYND: begin
                    s_q <= s_div;
                    if (last) begin
                        syn_q <= s_div;
                        cnt   <= '0;
                        state <= TRAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TRAP: begin
                    cw_q      <= cw_next;
                    s_q       <= hit ? '0 : s_shift;
                    trapped_q <= trap_any;
                    if (last) begin
                        cnt               <= '0;
                        out_valid         <= 1'b1;
                        out_data          <= cw_next[N-1:R];
                        out_syndrome      <= syn_q;
                        out_corrected     <= trap_any;
                        out_uncorrectable <= (syn_q != '0) & ~trap_any;
                        state             <= OUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_burst_trap_decoder.sv
// Scoreboard bench for burst_trap_decoder at (15,9), B=3.
// Expected results come from polynomial long division and brute-force burst search.
module tb_burst_trap_decoder;
    localparam int N = 15;
    localparam int K = 9;
    localparam int R = 6;
    localparam logic [6:0] GP = 7'b1111001;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [14:0]  in_data = '0;
    logic         correct_en = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [8:0]   out_data;
    logic [5:0]   out_syndrome;
    logic         out_corrected;
    logic         out_uncorrectable;

    typedef struct packed {
        logic [8:0] data;
        logic [5:0] syn;
        logic       corr;
        logic       unc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    burst_trap_decoder #(.N(N), .K(K), .B(3), .G(GP)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .correct_en(correct_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_syndrome(out_syndrome),
        .out_corrected(out_corrected),
        .out_uncorrectable(out_uncorrectable)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] mod_g(input logic [20:0] v);
        logic [20:0] t;
        t = v;
        for (int i = 20; i >= 6; i--)
            if (t[i]) t = t ^ (21'(GP) << (i - 6));
        return t[5:0];
    endfunction

    function automatic logic [5:0] syn_of(input logic [14:0] r);
        return mod_g({r, 6'b0});
    endfunction

    function automatic logic [14:0] encode(input logic [8:0] m);
        return {m, mod_g({6'b0, m, 6'b0})};
    endfunction

    function automatic logic [14:0] mk_burst(input int j, input logic [2:0] p);
        logic [14:0] e;
        e = '0;
        for (int t = 0; t < 3; t++)
            if (p[t]) e[(j + t) % N] = 1'b1;
        return e;
    endfunction

    function automatic exp_t model(input logic [14:0] r, input logic ce);
        exp_t        x;
        logic [14:0] fixed;
        logic [14:0] e;
        fixed  = r;
        x.syn  = syn_of(r);
        x.corr = 1'b0;
        if (ce && x.syn != 0)
            for (int j = 0; j < N; j++)
                for (int p = 1; p < 8; p += 2) begin
                    e = mk_burst(j, 3'(p));
                    if (!x.corr && syn_of(e) == x.syn) begin
                        x.corr = 1'b1;
                        fixed  = r ^ e;
                    end
                end
        x.unc  = (x.syn != 0) && !x.corr;
        x.data = fixed[14:6];
        return x;
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output data=%h", out_data);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.data) begin
                        n_fail++;
                        $display("FAIL out_data got=%h exp=%h", out_data, e.data);
                    end
                    n_cmp++;
                    if (out_syndrome !== e.syn) begin
                        n_fail++;
                        $display("FAIL out_syndrome got=%h exp=%h",
                                 out_syndrome, e.syn);
                    end
                    n_cmp++;
                    if (out_corrected !== e.corr) begin
                        n_fail++;
                        $display("FAIL out_corrected got=%b exp=%b",
                                 out_corrected, e.corr);
                    end
                    n_cmp++;
                    if (out_uncorrectable !== e.unc) begin
                        n_fail++;
                        $display("FAIL out_uncorrectable got=%b exp=%b",
                                 out_uncorrectable, e.unc);
                    end
                end
            end
        end
    endtask

    task automatic send(input logic [14:0] w, input logic ce);
        int n;
        n          = 0;
        in_data    = w;
        correct_en = ce;
        in_valid   = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout got=in_ready_low exp=in_ready_high");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL out_timeout got=no_out_valid exp=out_valid");
        end
    endtask

    task automatic run(input logic [14:0] w, input logic ce, input exp_t e);
        int lat;
        out_ready = 1'b1;
        send(w, ce);
        sb.push_back(e);
        wait_out(lat);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake got=%b%b exp=10", in_ready, out_valid);
        end
        n_cmp++;
        if (out_data !== 9'h0 || out_syndrome !== 6'h0) begin
            n_fail++;
            $display("FAIL reset_data got=%h/%h exp=0/0", out_data, out_syndrome);
        end
        n_cmp++;
        if (out_corrected !== 1'b0 || out_uncorrectable !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags got=%b%b exp=00",
                     out_corrected, out_uncorrectable);
        end
    endtask

    task automatic test_zero();
        int lat;
        out_ready = 1'b1;
        send(15'h0000, 1'b1);
        sb.push_back('{data: 9'h000, syn: 6'h00, corr: 1'b0, unc: 1'b0});
        wait_out(lat);
        n_cmp++;
        if (lat !== 30) begin
            n_fail++;
            $display("FAIL latency got=%0d exp=30", lat);
        end
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL in_ready_in_out got=%b exp=0", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run(15'h7000, 1'b1,
            '{data: 9'h000, syn: syn_of(15'h7000), corr: 1'b1, unc: 1'b0});
        run(15'h4001, 1'b1,
            '{data: 9'h000, syn: syn_of(15'h4001), corr: 1'b1, unc: 1'b0});
        run(15'h0079 ^ 15'h0007, 1'b1,
            '{data: 9'h001, syn: syn_of(15'h007E), corr: 1'b1, unc: 1'b0});
        run(15'h0013, 1'b1,
            '{data: 9'h000, syn: 6'h13, corr: 1'b0, unc: 1'b1});
    endtask

    task automatic test_detect_stall();
        int lat;
        out_ready = 1'b0;
        send(15'h7000, 1'b0);
        sb.push_back('{data: 9'h1C0, syn: syn_of(15'h7000), corr: 1'b0, unc: 1'b1});
        wait_out(lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 9'h1C0 ||
                out_uncorrectable !== 1'b1 || out_corrected !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold cyc=%0d got=%b/%h/%b exp=1/1c0/1",
                         i, out_valid, out_data, out_uncorrectable);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release got=%b%b exp=01", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        send(15'h7000, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset got=%b%b exp=01", out_valid, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL aborted_word got=%b exp=0", out_valid);
        end
        run(15'h0079 ^ 15'h0007, 1'b1, model(15'h007E, 1'b1));
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [14:0] w2;
        out_ready = 1'b1;
        w2 = encode(9'h155) ^ mk_burst(13, 3'b101);
        send(encode(9'h0AA) ^ mk_burst(4, 3'b011), 1'b1);
        sb.push_back(model(encode(9'h0AA) ^ mk_burst(4, 3'b011), 1'b1));
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data    = 15'($urandom);
            correct_en = 1'($urandom);
            @(posedge clk); #1;
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_in_ready got=%b exp=0", in_ready);
            end
        end
        send(w2, 1'b1);
        sb.push_back(model(w2, 1'b1));
        wait_out(lat);
        n_cmp++;
        if (lat !== 30) begin
            n_fail++;
            $display("FAIL b2b_latency got=%0d exp=30", lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [8:0]  m;
        logic [14:0] w;
        logic        ce;
        int          kind;
        int          lat;
        for (int i = 0; i < 24; i++) begin
            m    = 9'($urandom);
            kind = $urandom_range(0, 3);
            ce   = (kind != 2);
            w    = encode(m);
            if (kind == 1 || kind == 2)
                w = w ^ mk_burst($urandom_range(0, 14), {2'($urandom), 1'b1});
            if (kind == 3)
                w = w ^ (15'h1 << $urandom_range(0, 6)) ^ (15'h1 << $urandom_range(9, 14));
            out_ready = 1'b0;
            send(w, ce);
            sb.push_back(model(w, ce));
            wait_out(lat);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            out_ready = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        test_reset();
        test_zero();
        test_directed();
        test_detect_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_left got=%0d exp=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
